// File: rtl/altddio_in_deser_pkg.sv
// Shared types and helpers for the multi-lane DDR input deserializer.
// Contents:
//   lane_state_e   - per-lane alignment FSM states
//   calc_sw        - slip-offset width for a given word ratio
//   ratio_legal    - legality test for the RATIO parameter
package altddio_in_deser_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StCheck,
    StLocked,
    StFail
  } lane_state_e;

  localparam int unsigned RatioMin = 4;
  localparam int unsigned RatioMax = 16;

  function automatic int unsigned calc_sw(input int unsigned ratio);
    return $clog2(ratio);
  endfunction

  function automatic bit ratio_legal(input int unsigned ratio);
    return (ratio >= RatioMin) && (ratio <= RatioMax) && ((ratio % 2) == 0);
  endfunction

endpackage

// File: rtl/ddio_deser_lane.sv
// One deserializer lane: 2*RATIO-bit history shifter, slip window mux, slip counter and the
// alignment FSM that searches slip offsets for TRAIN_PATTERN.
// Ports:
//   clk, sclr          - clock, synchronous active-high reset
//   en                 - capture enable; all state holds when low
//   datain_h, datain_l - older / newer bit of this beat
//   bitslip            - manual slip pulse (honoured in idle or locked)
//   align_start        - restart alignment
//   word_end           - enabled edge that completes a word (from the shared beat counter)
//   dataout            - aligned word, MSB = oldest bit
//   locked, align_fail - alignment status
//   slip_pos           - current slip offset
module ddio_deser_lane
  import altddio_in_deser_pkg::*;
#(
  parameter int unsigned      RATIO         = 8,
  parameter logic [RATIO-1:0] TRAIN_PATTERN = 8'hE4,
  parameter int unsigned      SETTLE        = 2,
  parameter int unsigned      LOCK_COUNT    = 4,
  parameter bit               POWER_UP_HIGH = 1'b0,
  localparam int unsigned     SW            = calc_sw(RATIO)
) (
  input  logic             clk,
  input  logic             sclr,
  input  logic             en,
  input  logic             datain_h,
  input  logic             datain_l,
  input  logic             bitslip,
  input  logic             align_start,
  input  logic             word_end,
  output logic [RATIO-1:0] dataout,
  output logic             locked,
  output logic             align_fail,
  output logic [SW-1:0]    slip_pos
);

  localparam int unsigned HW = 2 * RATIO;
  localparam int unsigned TW = $clog2(RATIO + 1);
  localparam int unsigned MW = $clog2(LOCK_COUNT + 1);
  localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [HW-1:0]    HistRst    = {HW{POWER_UP_HIGH}};
  localparam logic [RATIO-1:0] DoutRst    = {RATIO{POWER_UP_HIGH}};
  localparam logic [SW-1:0]    SlipMax    = SW'(RATIO - 1);
  localparam logic [TW-1:0]    TriesMax   = TW'(RATIO);
  localparam logic [MW-1:0]    LockTarget = MW'(LOCK_COUNT);
  localparam logic [CW-1:0]    SettleLast = CW'((SETTLE > 0) ? SETTLE - 1 : 0);
  // With no settle words a slip goes straight back to comparing.
  localparam lane_state_e      StAfterSlip = (SETTLE == 0) ? StCheck : StSettle;

  lane_state_e      state_q, state_d;
  logic [HW-1:0]    hist_q, hist_d, hist_next, shifted;
  logic [RATIO-1:0] dout_q, dout_d, window;
  logic [SW-1:0]    slip_q, slip_d, slip_inc;
  logic [TW-1:0]    tries_q, tries_d, tries_inc;
  logic [MW-1:0]    match_q, match_d, match_inc;
  logic [CW-1:0]    settle_q, settle_d;
  logic             locked_q, locked_d, fail_q, fail_d;

  // Oldest history bits fall off the top.
  assign hist_next = HW'({hist_q, datain_h, datain_l});
  // Larger slip selects older bits.
  assign shifted   = hist_next >> slip_q;
  assign window    = shifted[RATIO-1:0];
  assign slip_inc  = (slip_q == SlipMax) ? '0 : slip_q + 1'b1;
  assign tries_inc = tries_q + 1'b1;
  assign match_inc = match_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    hist_d   = hist_q;
    dout_d   = dout_q;
    slip_d   = slip_q;
    tries_d  = tries_q;
    match_d  = match_q;
    settle_d = settle_q;
    locked_d = locked_q;
    fail_d   = fail_q;
    if (en) begin
      hist_d = hist_next;
      if (word_end) dout_d = window;
      if (align_start) begin
        state_d  = StAfterSlip;
        slip_d   = '0;
        tries_d  = '0;
        match_d  = '0;
        settle_d = '0;
        locked_d = 1'b0;
        fail_d   = 1'b0;
      end else begin
        if (bitslip && (state_q == StIdle || state_q == StLocked)) slip_d = slip_inc;
        if (word_end) begin
          case (state_q)
            StSettle: begin
              if (settle_q == SettleLast) begin
                settle_d = '0;
                state_d  = StCheck;
              end else begin
                settle_d = settle_q + 1'b1;
              end
            end
            StCheck: begin
              if (window == TRAIN_PATTERN) begin
                match_d = match_inc;
                if (match_inc == LockTarget) begin
                  state_d  = StLocked;
                  locked_d = 1'b1;
                end
              end else begin
                match_d = '0;
                tries_d = tries_inc;
                if (tries_inc == TriesMax) begin
                  state_d = StFail;
                  fail_d  = 1'b1;
                end else begin
                  slip_d   = slip_inc;
                  settle_d = '0;
                  state_d  = StAfterSlip;
                end
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      state_q  <= StIdle;
      hist_q   <= HistRst;
      dout_q   <= DoutRst;
      slip_q   <= '0;
      tries_q  <= '0;
      match_q  <= '0;
      settle_q <= '0;
      locked_q <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hist_q   <= hist_d;
      dout_q   <= dout_d;
      slip_q   <= slip_d;
      tries_q  <= tries_d;
      match_q  <= match_d;
      settle_q <= settle_d;
      locked_q <= locked_d;
      fail_q   <= fail_d;
    end
  end

  assign dataout    = dout_q;
  assign locked     = locked_q;
  assign align_fail = fail_q;
  assign slip_pos   = slip_q;

endmodule

// File: rtl/altddio_in_deser.sv
// Multi-lane DDR input deserializer with per-lane bitslip and automatic word alignment.
// Ports:
//   inclock, sclr       - sole clock, synchronous active-high reset
//   inclocken           - capture enable
//   datain_h, datain_l  - per-lane older / newer bit of each beat
//   bitslip             - per-lane manual slip pulse
//   align_start         - restart alignment on all lanes
//   dataout             - lane i at [i*RATIO +: RATIO], MSB = oldest bit
//   dataout_valid       - one-cycle pulse when dataout updates
//   locked, align_fail  - per-lane alignment status
//   slip_pos            - per-lane slip offset, SW bits each
module altddio_in_deser
  import altddio_in_deser_pkg::*;
#(
  parameter int unsigned      WIDTH         = 1,
  parameter int unsigned      RATIO         = 8,
  parameter logic [RATIO-1:0] TRAIN_PATTERN = 8'hE4,
  parameter int unsigned      SETTLE        = 2,
  parameter int unsigned      LOCK_COUNT    = 4,
  parameter string            POWER_UP_HIGH = "OFF",
  localparam int unsigned     SW            = calc_sw(RATIO)
) (
  input  logic                   inclock,
  input  logic                   sclr,
  input  logic                   inclocken,
  input  logic [WIDTH-1:0]       datain_h,
  input  logic [WIDTH-1:0]       datain_l,
  input  logic [WIDTH-1:0]       bitslip,
  input  logic                   align_start,
  output logic [WIDTH*RATIO-1:0] dataout,
  output logic                   dataout_valid,
  output logic [WIDTH-1:0]       locked,
  output logic [WIDTH-1:0]       align_fail,
  output logic [WIDTH*SW-1:0]    slip_pos
);

  if (!ratio_legal(RATIO)) begin : g_ratio_chk
    $error("altddio_in_deser: RATIO must be even and within 4..16");
  end

  localparam int unsigned   BW       = $clog2(RATIO / 2);
  localparam logic [BW-1:0] LastBeat = BW'(RATIO / 2 - 1);
  localparam bit            PuHigh   = (POWER_UP_HIGH == "ON");

  logic [BW-1:0] beat_q;
  logic          valid_q;
  logic          word_end;

  assign word_end = inclocken && (beat_q == LastBeat);

  always_ff @(posedge inclock) begin
    if (sclr) begin
      beat_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      // Valid is a pulse even if the enable drops on the following edge.
      valid_q <= word_end;
      if (inclocken) beat_q <= word_end ? '0 : beat_q + 1'b1;
    end
  end

  assign dataout_valid = valid_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    ddio_deser_lane #(
      .RATIO         (RATIO),
      .TRAIN_PATTERN (TRAIN_PATTERN),
      .SETTLE        (SETTLE),
      .LOCK_COUNT    (LOCK_COUNT),
      .POWER_UP_HIGH (PuHigh)
    ) u_lane (
      .clk         (inclock),
      .sclr        (sclr),
      .en          (inclocken),
      .datain_h    (datain_h[i]),
      .datain_l    (datain_l[i]),
      .bitslip     (bitslip[i]),
      .align_start (align_start),
      .word_end    (word_end),
      .dataout     (dataout[i*RATIO +: RATIO]),
      .locked      (locked[i]),
      .align_fail  (align_fail[i]),
      .slip_pos    (slip_pos[i*SW +: SW])
    );
  end

endmodule

// File: tb/tb_altddio_in_deser.sv
// Directed bench for altddio_in_deser with WIDTH=2, RATIO=8.
module tb_altddio_in_deser;

  localparam int unsigned W = 2;
  localparam int unsigned R = 8;

  logic           inclock = 1'b0;
  logic           sclr = 1'b1;
  logic           inclocken = 1'b1;
  logic [W-1:0]   datain_h = '0;
  logic [W-1:0]   datain_l = '0;
  logic [W-1:0]   bitslip = '0;
  logic           align_start = 1'b0;
  logic [W*R-1:0] dataout;
  logic           dataout_valid;
  logic [W-1:0]   locked;
  logic [W-1:0]   align_fail;
  logic [W*3-1:0] slip_pos;

  altddio_in_deser #(
    .WIDTH (W),
    .RATIO (R)
  ) dut (
    .inclock       (inclock),
    .sclr          (sclr),
    .inclocken     (inclocken),
    .datain_h      (datain_h),
    .datain_l      (datain_l),
    .bitslip       (bitslip),
    .align_start   (align_start),
    .dataout       (dataout),
    .dataout_valid (dataout_valid),
    .locked        (locked),
    .align_fail    (align_fail),
    .slip_pos      (slip_pos)
  );

  always #5 inclock = ~inclock;

  int vectors = 0;
  int miscompares = 0;
  int beat = 0;        // model of the shared beat counter
  int mode = 0;        // 0: manual data, 1: lane0 pattern stream, lane1 zeros
  logic [7:0] pat = 8'h93;

  typedef struct {
    logic [1:0]  h;
    logic [1:0]  l;
    logic [1:0]  slip;
    logic [15:0] exp_dout;
    logic [5:0]  exp_slip;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    if (mode == 1) begin
      datain_h[0] = pat[7-2*beat];
      datain_l[0] = pat[6-2*beat];
      datain_h[1] = 1'b0;
      datain_l[1] = 1'b0;
    end
    @(posedge inclock);
    if (sclr) beat = 0;
    else if (inclocken) beat = (beat + 1) % 4;
    #1;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    tick();
    while (!dataout_valid && n < 16) begin
      tick();
      n++;
    end
    check({name, "_timeout"}, 64'(dataout_valid), 64'd1);
  endtask

  task automatic run_vec(input int idx);
    datain_h = vecs[idx].h;
    datain_l = vecs[idx].l;
    bitslip  = vecs[idx].slip;
    tick();
    bitslip = '0;
    if (!dataout_valid) wait_valid($sformatf("vec%0d_w1", idx));
    wait_valid($sformatf("vec%0d_w2", idx));
    check($sformatf("vec%0d_dout", idx), 64'(dataout), 64'(vecs[idx].exp_dout));
    check($sformatf("vec%0d_slip", idx), 64'(slip_pos), 64'(vecs[idx].exp_slip));
  endtask

  // Align from align_start: lane0 sees 93, C9, E4 (three words each slip until lock);
  // lane1 at constant zero exhausts all eight offsets after 24 words.
  task automatic run_align(input string tag, input bit full);
    logic [7:0] exp_w[12];
    exp_w = '{8'h93, 8'h93, 8'h93, 8'hC9, 8'hC9, 8'hC9,
              8'hE4, 8'hE4, 8'hE4, 8'hE4, 8'hE4, 8'hE4};
    align_start = 1'b1;
    tick();
    align_start = 1'b0;
    for (int w = 0; w < (full ? 24 : 12); w++) begin
      wait_valid($sformatf("%s_w%0d", tag, w));
      if (w < 12) check($sformatf("%s_word%0d", tag, w), 64'(dataout[7:0]), 64'(exp_w[w]));
      if (w == 10) check({tag, "_not_yet_locked"}, 64'(locked[0]), 64'd0);
      if (w == 11) begin
        check({tag, "_locked0"}, 64'(locked[0]), 64'd1);
        check({tag, "_slip0"}, 64'(slip_pos[2:0]), 64'd2);
      end
      if (w == 22) check({tag, "_fail1_early"}, 64'(align_fail[1]), 64'd0);
      if (w == 23) begin
        check({tag, "_fail1"}, 64'(align_fail[1]), 64'd1);
        check({tag, "_locked1"}, 64'(locked[1]), 64'd0);
        check({tag, "_slip1"}, 64'(slip_pos[5:3]), 64'd7);
        check({tag, "_fail0"}, 64'(align_fail[0]), 64'd0);
        check({tag, "_still_locked0"}, 64'(locked[0]), 64'd1);
      end
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_dout"}, 64'(dataout), 64'd0);
    check({tag, "_valid"}, 64'(dataout_valid), 64'd0);
    check({tag, "_locked"}, 64'(locked), 64'd0);
    check({tag, "_fail"}, 64'(align_fail), 64'd0);
    check({tag, "_slip"}, 64'(slip_pos), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nvalid;
    vecs[0] = '{h: 2'b01, l: 2'b10, slip: 2'b00, exp_dout: 16'h55AA, exp_slip: 6'o00};
    vecs[1] = '{h: 2'b01, l: 2'b10, slip: 2'b01, exp_dout: 16'h5555, exp_slip: 6'o01};
    vecs[2] = '{h: 2'b01, l: 2'b10, slip: 2'b10, exp_dout: 16'hAA55, exp_slip: 6'o11};
    vecs[3] = '{h: 2'b11, l: 2'b11, slip: 2'b00, exp_dout: 16'hFFFF, exp_slip: 6'o11};
    vecs[4] = '{h: 2'b00, l: 2'b00, slip: 2'b00, exp_dout: 16'h0000, exp_slip: 6'o11};
    vecs[5] = '{h: 2'b01, l: 2'b01, slip: 2'b11, exp_dout: 16'h00FF, exp_slip: 6'o22};
    vecs[6] = '{h: 2'b10, l: 2'b01, slip: 2'b00, exp_dout: 16'hAA55, exp_slip: 6'o22};

    // Reset with enable high and random data.
    sclr = 1'b1;
    inclocken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      datain_h = W'($urandom);
      datain_l = W'($urandom);
      tick();
    end
    check_reset("reset");

    // Released but disabled: no word may appear.
    sclr = 1'b0;
    inclocken = 1'b0;
    nvalid = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (dataout_valid) nvalid++;
    end
    check("disabled_no_valid", 64'(nvalid), 64'd0);

    // Framing: valid on every 4th enabled edge, first on the 4th.
    inclocken = 1'b1;
    datain_h = 2'b01;
    datain_l = 2'b10;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("frame_valid_edge%0d", k), 64'(dataout_valid), 64'((k % 4) == 0));
      if (k == 4) check("frame_first_word", 64'(dataout), 64'h55AA);
    end

    // Table: manual slips in idle and plain capture.
    for (int i = 0; i < 7; i++) run_vec(i);

    // Alignment on lane0 (pattern stream) with lane1 failing on zeros.
    mode = 1;
    for (int i = 0; i < 8; i++) tick();
    run_align("align", 1'b1);

    // Manual slip while locked keeps lock; in fail it is ignored.
    bitslip = 2'b11;
    tick();
    bitslip = '0;
    if (!dataout_valid) wait_valid("lslip_w1");
    wait_valid("lslip_w2");
    check("lslip_word", 64'(dataout), 64'h0072);
    check("lslip_locked", 64'(locked), 64'b01);
    check("lslip_slip", 64'(slip_pos), 64'o73);
    check("lslip_fail", 64'(align_fail), 64'b10);

    // Reset in the middle of settling, enable low on the reset edge.
    align_start = 1'b1;
    tick();
    align_start = 1'b0;
    wait_valid("mid_settle");
    sclr = 1'b1;
    inclocken = 1'b0;
    tick();
    check_reset("midrst");
    sclr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      inclocken = i[0];
      tick();
      check($sformatf("midrst_toggle%0d_valid", i), 64'(dataout_valid), 64'd0);
    end
    inclocken = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    run_align("realign", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
